phase_timer: RTL and testbench
==============================

PHASE_TIMER -- requirements
Module: phase_timer

Interface
REQ-001 SHALL take parameter NUM_PHASES, default 3, meaning the number of timed phases (minimum 2).
REQ-002 SHALL take parameter CNT_W, default 8, meaning the width of the counter and duration fields.
REQ-003 SHALL have port clk  input  1  clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port tick_en  input  1  time-base strobe; one counted unit per high cycle.
REQ-006 SHALL have port phase_sel  input  NUM_PHASES  one-hot active-phase request from the FSM.
REQ-007 SHALL have port pause  input  1  freezes counting while high.
REQ-008 SHALL have port cfg_we  input  1  duration-table write strobe.
REQ-009 SHALL have port cfg_idx  input  clog2(NUM_PHASES)  duration-table write index.
REQ-010 SHALL have port cfg_data  input  CNT_W  duration value to write.
REQ-011 SHALL have port phase_end  output  NUM_PHASES  one-cycle pulse; bit i means phase i has expired.
REQ-012 SHALL have port remaining  output  CNT_W  units left in the active phase, for the countdown display.
REQ-013 SHALL have port sel_err  output  1  high while phase_sel is zero or multi-hot.

Function
REQ-014 SHALL hold a duration table dur[NUM_PHASES]; the write takes effect when cfg_we=1 and cfg_idx<NUM_PHASES; out-of-range writes are ignored.
REQ-015 SHALL register phase_sel as sel_q each cycle; a phase start is a valid one-hot phase_sel that differs from sel_q.
REQ-016 SHALL, on a phase start, clear cnt to 0 and latch act_dur = max(dur[new phase], 1); a same-cycle cfg write to that index supplies the latched value.
REQ-017 SHALL ignore table writes for the running phase until its next phase start.
REQ-018 SHALL count only on a qualified tick: tick_en=1, pause=0, phase_sel valid one-hot, and no phase start in that cycle.
REQ-019 SHALL, on a qualified tick with cnt < act_dur-1, increment cnt by 1.
REQ-020 SHALL, on a qualified tick with cnt == act_dur-1, set cnt to 0 and pulse phase_end[active] high for exactly the next cycle (registered, 1-cycle latency).
REQ-021 SHALL, if phase_sel stays unchanged after expiry, restart timing with the same act_dur (periodic pulses).
REQ-022 SHALL drive remaining = act_dur - cnt, combinational from registers; remaining is never 0 while the select is valid.
REQ-023 SHALL, while the select is invalid, hold cnt at 0, suppress phase_end, drive remaining 0 and sel_err 1.
REQ-024 SHALL, while pause=1, hold cnt and not pulse phase_end; remaining stays constant.
REQ-025 SHALL never assert more than one phase_end bit per cycle.
REQ-026 SHALL never wrap cnt; all arithmetic is CNT_W bits unsigned.

Reset
REQ-027 SHALL, on rst_n=0 at a clock edge, clear cnt, sel_q, act_dur and phase_end to 0.
REQ-028 SHALL, on reset, load dur[i] from the package defaults (0:15, 1:5, 2:2, others:1).
REQ-029 SHALL make reset override all other inputs, including mid-phase and same-cycle cfg_we; outputs are remaining=0 and sel_err per the current phase_sel.
REQ-030 SHALL treat the first valid select after reset as a phase start.

Structure
REQ-031 SHALL place the default duration table, the phase index constants (GREEN=0, YELLOW=1, RED=2) and the CNT_W default in the shared package phase_timer_pkg.
REQ-032 SHALL implement one sub-module, phase_dur_table (register file with reset defaults and write port); counter and compare logic stay in phase_timer.

Verification
REQ-033 SHALL cover the default run: reset, phase_sel=001, tick_en=1 constant -> phase_end[0] pulses 15 clocks after the first counted tick; remaining steps 15..1.
REQ-034 SHALL cover a mid-phase write: during phase 0, write dur[0]=4 -> current phase still ends at 15; the next phase-0 start ends after 4 ticks.
REQ-035 SHALL cover pause: pause for 10 cycles at cnt=7 of phase 1 (dur 5 overridden to 10) -> remaining is frozen at 3; the end pulse is delayed exactly 10 cycles.
REQ-036 SHALL cover a bad select: phase_sel=011 -> sel_err=1, remaining=0, no phase_end; on return to 100 -> timing restarts from 2.
REQ-037 SHALL cover a zero duration and a same-cycle write: dur[2]=0 -> phase 2 ends every tick; a cfg write to idx 2 coinciding with phase-2 start -> the new value is used.
REQ-038 SHALL cover reset at cnt=9 of phase 0 -> cnt=0, phase_end=0 and the table restored to defaults the next cycle.

Source files
------------

// File: rtl/phase_timer_pkg.sv
// Shared phase indices and duration defaults for the phase timer.
// Pure constants and one helper function; no logic, no latency.
package phase_timer_pkg;

    localparam int CNT_W_DEF = 8;

    localparam int GREEN  = 0;
    localparam int YELLOW = 1;
    localparam int RED    = 2;

    // Reset value of each phase's duration, in time-base ticks.
    function automatic int default_dur(input int idx);
        case (idx)
            GREEN:   default_dur = 15;
            YELLOW:  default_dur = 5;
            RED:     default_dur = 2;
            default: default_dur = 1;
        endcase
    endfunction

endpackage

// File: rtl/phase_dur_table.sv
// Per-phase duration register file; writes land one cycle after cfg strobe.
// Always accepts writes (no backpressure); out-of-range indices are dropped.
module phase_dur_table
    import phase_timer_pkg::*;
#(
    parameter int NUM_PHASES = 3,
    parameter int CNT_W      = CNT_W_DEF,
    parameter int IDX_W      = $clog2(NUM_PHASES)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we_i,
    input  logic [IDX_W-1:0] idx_i,
    input  logic [CNT_W-1:0] data_i,
    output logic [CNT_W-1:0] dur_o [NUM_PHASES]
);

    logic [CNT_W-1:0] dur_q [NUM_PHASES];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_PHASES; i++) begin
                dur_q[i] <= CNT_W'(default_dur(i));
            end
        end else if (we_i && (int'(idx_i) < NUM_PHASES)) begin
            dur_q[idx_i] <= data_i;
        end
    end

    assign dur_o = dur_q;

endmodule

// File: rtl/phase_timer.sv
// Per-phase countdown timer; phase_end is registered (1 cycle after the last tick).
// No backpressure: pause freezes the count, an invalid select parks it at zero.
module phase_timer
    import phase_timer_pkg::*;
#(
    parameter int NUM_PHASES = 3,
    parameter int CNT_W      = CNT_W_DEF
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          tick_en,
    input  logic [NUM_PHASES-1:0]         phase_sel,
    input  logic                          pause,
    input  logic                          cfg_we,
    input  logic [$clog2(NUM_PHASES)-1:0] cfg_idx,
    input  logic [CNT_W-1:0]              cfg_data,
    output logic [NUM_PHASES-1:0]         phase_end,
    output logic [CNT_W-1:0]              remaining,
    output logic                          sel_err
);

    localparam int IDX_W = $clog2(NUM_PHASES);

    logic [CNT_W-1:0]      dur [NUM_PHASES];
    logic [NUM_PHASES-1:0] sel_q, sel_d;
    logic [NUM_PHASES-1:0] pend_q, pend_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [CNT_W-1:0]      act_q, act_d;
    logic                  sel_valid;
    logic                  start;
    logic                  qual_tick;
    logic [IDX_W-1:0]      new_idx;
    logic [CNT_W-1:0]      new_dur;

    phase_dur_table #(
        .NUM_PHASES (NUM_PHASES),
        .CNT_W      (CNT_W),
        .IDX_W      (IDX_W)
    ) u_dur_table (
        .clk    (clk),
        .rst_n  (rst_n),
        .we_i   (cfg_we),
        .idx_i  (cfg_idx),
        .data_i (cfg_data),
        .dur_o  (dur)
    );

    assign sel_valid = $onehot(phase_sel);
    assign start     = sel_valid && (phase_sel != sel_q);
    assign qual_tick = tick_en && !pause && sel_valid && !start;

    always_comb begin
        new_idx = '0;
        for (int i = 0; i < NUM_PHASES; i++) begin
            if (phase_sel[i]) begin
                new_idx = IDX_W'(i);
            end
        end
    end

    // A write to the starting phase's slot in the same cycle wins over the table.
    assign new_dur = (cfg_we && (cfg_idx == new_idx)) ? cfg_data : dur[new_idx];

    always_comb begin
        cnt_d  = cnt_q;
        act_d  = act_q;
        pend_d = '0;
        sel_d  = phase_sel;
        if (!sel_valid) begin
            cnt_d = '0;
        end else if (start) begin
            cnt_d = '0;
            act_d = (new_dur == '0) ? CNT_W'(1) : new_dur;
        end else if (qual_tick) begin
            if (cnt_q >= act_q - CNT_W'(1)) begin
                cnt_d  = '0;
                pend_d = phase_sel;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sel_q  <= '0;
            pend_q <= '0;
            cnt_q  <= '0;
            act_q  <= '0;
        end else begin
            sel_q  <= sel_d;
            pend_q <= pend_d;
            cnt_q  <= cnt_d;
            act_q  <= act_d;
        end
    end

    assign phase_end = pend_q;
    assign remaining = sel_valid ? (act_q - cnt_q) : '0;
    assign sel_err   = !sel_valid;

endmodule

// File: tb/tb_phase_timer.sv
// Scoreboard bench for phase_timer: reference model pushes expected outputs per cycle.
module tb_phase_timer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       tick_en;
    logic [2:0] phase_sel;
    logic       pause;
    logic       cfg_we;
    logic [1:0] cfg_idx;
    logic [7:0] cfg_data;
    logic [2:0] phase_end;
    logic [7:0] remaining;
    logic       sel_err;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct packed {
        logic [2:0] pe;
        logic [7:0] rem;
        logic       err;
    } exp_t;

    exp_t exp_q[$];

    int         m_dur [3];
    logic [2:0] m_sel;
    int         m_cnt;
    int         m_act;
    logic [2:0] m_pe;

    always #5 clk = ~clk;

    phase_timer #(
        .NUM_PHASES (3),
        .CNT_W      (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .tick_en   (tick_en),
        .phase_sel (phase_sel),
        .pause     (pause),
        .cfg_we    (cfg_we),
        .cfg_idx   (cfg_idx),
        .cfg_data  (cfg_data),
        .phase_end (phase_end),
        .remaining (remaining),
        .sel_err   (sel_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference behaviour for one rising edge with the given inputs held.
    task automatic model_edge(input bit rst, input bit tick, input bit pse, input logic [2:0] sel,
                              input bit we, input logic [1:0] idx, input logic [7:0] data);
        bit         valid;
        bit         started;
        int         k;
        int         d;
        logic [2:0] nxt_pe;
        exp_t       e;
        valid = ($countones(sel) == 1);
        if (rst) begin
            m_cnt = 0;
            m_sel = 3'b000;
            m_act = 0;
            m_pe  = 3'b000;
            m_dur[0] = 15;
            m_dur[1] = 5;
            m_dur[2] = 2;
        end else begin
            started = valid && (sel != m_sel);
            nxt_pe  = 3'b000;
            if (!valid) begin
                m_cnt = 0;
            end else if (started) begin
                k = 0;
                for (int i = 0; i < 3; i++) if (sel[i]) k = i;
                d = (we && int'(idx) == k) ? int'(data) : m_dur[k];
                m_act = (d == 0) ? 1 : d;
                m_cnt = 0;
            end else if (tick && !pse) begin
                m_cnt++;
                if (m_cnt == m_act) begin
                    m_cnt  = 0;
                    nxt_pe = sel;
                end
            end
            if (we && idx < 2'd3) m_dur[idx] = int'(data);
            m_sel = sel;
            m_pe  = nxt_pe;
        end
        e.pe  = m_pe;
        e.rem = valid ? 8'(m_act - m_cnt) : 8'd0;
        e.err = !valid;
        exp_q.push_back(e);
    endtask

    task automatic step(input bit rst, input bit tick, input bit pse, input logic [2:0] sel,
                        input bit we, input logic [1:0] idx, input logic [7:0] data);
        exp_t e;
        rst_n     = !rst;
        tick_en   = tick;
        pause     = pse;
        phase_sel = sel;
        cfg_we    = we;
        cfg_idx   = idx;
        cfg_data  = data;
        model_edge(rst, tick, pse, sel, we, idx, data);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        chk("phase_end", 32'(phase_end), 32'(e.pe));
        chk("remaining", 32'(remaining), 32'(e.rem));
        chk("sel_err", 32'(sel_err), 32'(e.err));
        chk("pe_onehot0", 32'($countones(phase_end) <= 1), 32'd1);
    endtask

    task automatic tk(input logic [2:0] sel, input bit tick);
        step(1'b0, tick, 1'b0, sel, 1'b0, 2'd0, 8'd0);
    endtask

    task automatic wr(input logic [2:0] sel, input bit tick, input logic [1:0] idx, input logic [7:0] data);
        step(1'b0, tick, 1'b0, sel, 1'b1, idx, data);
    endtask

    // Ticks until phase_end fires; checks the number of ticks taken.
    task automatic run_to_end(input logic [2:0] sel, input string tag, input int exp_n);
        int n    = 0;
        bit seen = 1'b0;
        while (!seen && n < 64) begin
            tk(sel, 1'b1);
            n++;
            if (phase_end != 3'b000) seen = 1'b1;
        end
        chk(tag, 32'(n), 32'(exp_n));
    endtask

    initial begin
        rst_n = 1'b0; tick_en = 1'b0; pause = 1'b0; phase_sel = 3'b000;
        cfg_we = 1'b0; cfg_idx = 2'd0; cfg_data = 8'd0;

        // Reset, with a config write that must be overridden.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 3'b001, 1'b1, 2'd0, 8'd99);
        chk("rst_remaining", 32'(remaining), 32'd0);
        chk("rst_phase_end", 32'(phase_end), 32'd0);

        // Default run of phase 0.
        tk(3'b001, 1'b1);
        chk("rem_start0", 32'(remaining), 32'd15);
        run_to_end(3'b001, "end0_default", 15);

        // Mid-phase write to dur[0] leaves the running period at 15.
        for (int i = 0; i < 3; i++) tk(3'b001, 1'b1);
        wr(3'b001, 1'b1, 2'd0, 8'd4);
        run_to_end(3'b001, "end0_after_write", 11);
        tk(3'b010, 1'b0);
        tk(3'b001, 1'b0);
        chk("rem_start0_new", 32'(remaining), 32'd4);
        run_to_end(3'b001, "end0_new_dur", 4);

        // Pause at cnt=7 of phase 1 with dur 10.
        wr(3'b001, 1'b0, 2'd1, 8'd10);
        tk(3'b010, 1'b0);
        for (int i = 0; i < 7; i++) tk(3'b010, 1'b1);
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b1, 1'b1, 3'b010, 1'b0, 2'd0, 8'd0);
            chk("rem_paused", 32'(remaining), 32'd3);
        end
        run_to_end(3'b010, "end1_after_pause", 3);

        // Multi-hot select, then recovery onto phase 2.
        for (int i = 0; i < 5; i++) tk(3'b011, 1'b1);
        chk("bad_sel_err", 32'(sel_err), 32'd1);
        chk("bad_sel_rem", 32'(remaining), 32'd0);
        tk(3'b100, 1'b0);
        chk("rem_start2", 32'(remaining), 32'd2);
        run_to_end(3'b100, "end2_default", 2);

        // Zero duration and same-cycle write at phase start.
        wr(3'b100, 1'b0, 2'd2, 8'd0);
        run_to_end(3'b100, "end2_running_ignores_write", 2);
        tk(3'b001, 1'b0);
        tk(3'b100, 1'b0);
        chk("rem_zero_dur", 32'(remaining), 32'd1);
        for (int i = 0; i < 3; i++) run_to_end(3'b100, "end2_zero", 1);
        tk(3'b001, 1'b0);
        wr(3'b100, 1'b0, 2'd2, 8'd3);
        chk("rem_same_cycle_write", 32'(remaining), 32'd3);
        wr(3'b100, 1'b0, 2'd3, 8'd50);
        run_to_end(3'b100, "end2_same_cycle", 3);

        // Reset at cnt=9 of phase 0 restores the table.
        wr(3'b001, 1'b0, 2'd0, 8'd20);
        for (int i = 0; i < 9; i++) tk(3'b001, 1'b1);
        chk("rem_cnt9", 32'(remaining), 32'd11);
        step(1'b1, 1'b1, 1'b0, 3'b001, 1'b1, 2'd0, 8'd7);
        chk("mid_rst_remaining", 32'(remaining), 32'd0);
        chk("mid_rst_phase_end", 32'(phase_end), 32'd0);
        tk(3'b001, 1'b0);
        chk("rst_restored_dur0", 32'(remaining), 32'd15);
        tk(3'b010, 1'b0);
        chk("rst_restored_dur1", 32'(remaining), 32'd5);

        // Randomised traffic against the model.
        for (int i = 0; i < 400; i++) begin
            logic [2:0] s;
            int         r;
            r = $urandom_range(0, 19);
            if (r < 14)      s = 3'b001 << $urandom_range(0, 2);
            else if (r < 17) s = phase_sel;
            else if (r < 19) s = 3'b011;
            else             s = 3'b000;
            step(($urandom_range(0, 63) == 0), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 7) == 0), s, ($urandom_range(0, 7) == 0),
                 2'($urandom_range(0, 3)), 8'($urandom_range(0, 12)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
